// File: rtl/avr_prefetch_queue_if.sv
// Bundle of the prefetch queue's fetch-side and consumer-side signals.
// The slave modport is the queue. The master modport is the core or memory
// side that drives the queue.
interface avr_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush;
  logic [15:0]   flush_addr;
  logic          pm_en;
  logic [15:0]   pm_addr;
  logic [15:0]   pm_data;
  logic          out_valid;
  logic [15:0]   out_instr;
  logic [15:0]   out_pc;
  logic          out_pop;
  logic [LW-1:0] level;

  modport slave (
    input  flush, flush_addr, pm_data, out_pop,
    output pm_en, pm_addr, out_valid, out_instr, out_pc, level
  );

  modport master (
    output flush, flush_addr, pm_data, out_pop,
    input  pm_en, pm_addr, out_valid, out_instr, out_pc, level
  );
endinterface

// File: rtl/avr_prefetch_queue.sv
// Instruction prefetch queue for an AVR-style core.
// It issues one program-memory read per cycle while there is room.
// There is room when the queued entries plus the single read still
// outstanding fit in DEPTH.
// Each returning word is stored together with the address it was fetched
// from.
// A flush drops the queue contents and the outstanding read, then restarts
// fetching at a new address.
module avr_prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  avr_prefetch_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [31:0]   entries_q [DEPTH];
  logic [15:0]   fetchPc_q, fetchPc_d;
  logic [15:0]   tag_q, tag_d;
  logic          inflight_q, inflight_d;
  ptr_t          rdPtr_q, rdPtr_d;
  ptr_t          wrPtr_q, wrPtr_d;
  logic [LW-1:0] level_q, level_d;

  logic          pmEn;
  logic          doPush;
  logic          doPop;
  logic          headValid;

  // Request and handshake qualifiers.
  // The outstanding read counts against free space, so a returning word
  // always has a slot waiting for it.
  always_comb begin
    pmEn      = !RST && !bus.flush &&
                ((int'(level_q) + int'(inflight_q)) < DEPTH);
    doPush    = !RST && !bus.flush && inflight_q;
    doPop     = !RST && !bus.flush && bus.out_pop && (level_q != '0);
    headValid = !RST && (level_q != '0);
  end

  // Next-state computation.
  // A flush overrides push, pop and any new request. The outstanding read
  // is cancelled because pmEn is low in a flush cycle.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    tag_d      = tag_q;
    inflight_d = pmEn;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    level_d    = level_q;

    if (bus.flush) begin
      fetchPc_d = bus.flush_addr;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      level_d   = '0;
    end else begin
      if (pmEn) begin
        fetchPc_d = fetchPc_q + 16'd1;
        tag_d     = fetchPc_q;
      end
      if (doPush) begin
        wrPtr_d = wrPtr_q + ptr_t'(1);
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + ptr_t'(1);
      end
      case ({doPush, doPop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetchPc_q  <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      level_q    <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      level_q    <= level_d;
    end
  end

  // Entry storage.
  // Each entry holds the returning word in the upper half and the address
  // it came from in the lower half. No reset is needed because the outputs
  // are masked while the queue is empty.
  always_ff @(posedge CLK) begin
    if (doPush) begin
      entries_q[wrPtr_q] <= {bus.pm_data, tag_q};
    end
  end

  // Drive the bus outputs.
  // The head fields read as zero whenever there is nothing valid to show.
  always_comb begin
    bus.pm_en     = pmEn;
    bus.pm_addr   = fetchPc_q;
    bus.level     = level_q;
    bus.out_valid = headValid;
    bus.out_instr = headValid ? entries_q[rdPtr_q][31:16] : 16'h0000;
    bus.out_pc    = headValid ? entries_q[rdPtr_q][15:0]  : 16'h0000;
  end
endmodule

// File: tb/tb_avr_prefetch_queue.sv
// Directed bench for avr_prefetch_queue.
// Program memory is modelled as a one-cycle-latency ROM whose word at
// address A is 0x1000 + A.
module tb_avr_prefetch_queue;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  avr_prefetch_queue_if #(.DEPTH(4)) bus ();

  avr_prefetch_queue #(.DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // One-cycle-latency program memory.
  always @(posedge CLK) begin
    bus.pm_data <= 16'h1000 + bus.pm_addr;
  end

  // Advance one cycle, then drive this cycle's inputs and let them settle.
  task automatic applyStimulus(input logic rst, input logic flush,
                               input logic [15:0] faddr, input logic pop);
    @(posedge CLK);
    #1;
    RST            = rst;
    bus.flush      = flush;
    bus.flush_addr = faddr;
    bus.out_pop    = pop;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    bus.flush      = 1'b0;
    bus.flush_addr = 16'h0000;
    bus.out_pop    = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("rst_pm_en", {15'd0, bus.pm_en}, 16'd0);
    checkOutput("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    checkOutput("rst_instr", bus.out_instr, 16'h0000);
    checkOutput("rst_pc", bus.out_pc, 16'h0000);
    checkOutput("rst_level", 16'(bus.level), 16'd0);

    // Reset release and initial fill with no consumer
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fill0_pm_en", {15'd0, bus.pm_en}, 16'd1);
    checkOutput("fill0_addr", bus.pm_addr, 16'h0000);
    checkOutput("fill0_valid", {15'd0, bus.out_valid}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fill1_addr", bus.pm_addr, 16'h0001);
    checkOutput("fill1_level", 16'(bus.level), 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fill2_valid", {15'd0, bus.out_valid}, 16'd1);
    checkOutput("fill2_pc", bus.out_pc, 16'h0000);
    checkOutput("fill2_instr", bus.out_instr, 16'h1000);
    checkOutput("fill2_level", 16'(bus.level), 16'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fill3_level", 16'(bus.level), 16'd2);
    checkOutput("fill3_pm_en", {15'd0, bus.pm_en}, 16'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fill4_level", 16'(bus.level), 16'd3);
    checkOutput("fill4_pm_en", {15'd0, bus.pm_en}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fill5_level", 16'(bus.level), 16'd4);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("full_level", 16'(bus.level), 16'd4);
    checkOutput("full_pm_en", {15'd0, bus.pm_en}, 16'd0);
    checkOutput("full_pc", bus.out_pc, 16'h0000);
    checkOutput("full_instr", bus.out_instr, 16'h1000);
    checkOutput("full_addr", bus.pm_addr, 16'h0004);

    // Steady stream with the consumer always popping
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      checkOutput("stream_valid", {15'd0, bus.out_valid}, 16'd1);
      checkOutput("stream_pc", bus.out_pc, 16'(k));
      checkOutput("stream_instr", bus.out_instr, 16'h1000 + 16'(k));
    end

    // Flush while the reservation is full, with a read outstanding
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("pre_flush_pc", bus.out_pc, 16'h000A);
    checkOutput("pre_flush_level", 16'(bus.level), 16'd2);
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
    checkOutput("flush_level_before", 16'(bus.level), 16'd3);
    checkOutput("flush_pm_en", {15'd0, bus.pm_en}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("flush1_valid", {15'd0, bus.out_valid}, 16'd0);
    checkOutput("flush1_level", 16'(bus.level), 16'd0);
    checkOutput("flush1_pm_en", {15'd0, bus.pm_en}, 16'd1);
    checkOutput("flush1_addr", bus.pm_addr, 16'h0040);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("flush2_valid", {15'd0, bus.out_valid}, 16'd0);
    checkOutput("flush2_level", 16'(bus.level), 16'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      checkOutput("after_flush_valid", {15'd0, bus.out_valid}, 16'd1);
      checkOutput("after_flush_pc", bus.out_pc, 16'h0040 + 16'(k));
      checkOutput("after_flush_instr", bus.out_instr, 16'h1040 + 16'(k));
    end

    // Flush and pop together at level 3
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fp_level1", 16'(bus.level), 16'd1);
    checkOutput("fp_head", bus.out_pc, 16'h0043);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fp_level2", 16'(bus.level), 16'd2);
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1);
    checkOutput("fp_level3", 16'(bus.level), 16'd3);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fp1_level", 16'(bus.level), 16'd0);
    checkOutput("fp1_valid", {15'd0, bus.out_valid}, 16'd0);
    checkOutput("fp1_addr", bus.pm_addr, 16'h0100);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fp2_valid", {15'd0, bus.out_valid}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("fp3_valid", {15'd0, bus.out_valid}, 16'd1);
    checkOutput("fp3_pc", bus.out_pc, 16'h0100);
    checkOutput("fp3_instr", bus.out_instr, 16'h1100);

    // Fetch address wrap through 0xFFFF
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1);
    checkOutput("wrap_flush_level", 16'(bus.level), 16'd2);
    checkOutput("wrap_flush_pm_en", {15'd0, bus.pm_en}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("wrap1_level", 16'(bus.level), 16'd0);
    checkOutput("wrap1_addr", bus.pm_addr, 16'hFFFE);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("wrap2_valid", {15'd0, bus.out_valid}, 16'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      checkOutput("wrap_valid", {15'd0, bus.out_valid}, 16'd1);
      checkOutput("wrap_pc", bus.out_pc, 16'hFFFE + 16'(k));
      checkOutput("wrap_instr", bus.out_instr, 16'h0FFE + 16'(k));
    end

    // Reset asserted mid-stream at level 2
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("mid_level1", 16'(bus.level), 16'd1);
    checkOutput("mid_head", bus.out_pc, 16'h0002);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("mid_rst_level", 16'(bus.level), 16'd2);
    checkOutput("mid_rst_pm_en", {15'd0, bus.pm_en}, 16'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
    checkOutput("mid_rst_pm_en2", {15'd0, bus.pm_en}, 16'd0);
    checkOutput("mid_rst_level2", 16'(bus.level), 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("refill0_pm_en", {15'd0, bus.pm_en}, 16'd1);
    checkOutput("refill0_addr", bus.pm_addr, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("refill1_addr", bus.pm_addr, 16'h0001);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("refill2_valid", {15'd0, bus.out_valid}, 16'd1);
    checkOutput("refill2_pc", bus.out_pc, 16'h0000);
    checkOutput("refill2_instr", bus.out_instr, 16'h1000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/avr_prefetch_queue.md
AVR_PREFETCH_QUEUE -- requirements
Module: avr_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction-word queue entries (power of two, 2..8).
REQ-002 SHALL have CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have flush  input  1  discard queue and in-flight read, restart fetch at flush_addr.
REQ-005 SHALL have flush_addr  input  16  word address for restart.
REQ-006 SHALL have pm_en  output  1  program-memory read request this cycle.
REQ-007 SHALL have pm_addr  output  16  program-memory word address.
REQ-008 SHALL have pm_data  input  16  program-memory read data, valid one cycle after the request.
REQ-009 SHALL have out_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have out_instr  output  16  head instruction word, passed through unmodified.
REQ-011 SHALL have out_pc  output  16  word address of the head instruction.
REQ-012 SHALL have out_pop  input  1  consumer takes the head this cycle.
REQ-013 SHALL have level  output  clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-014 SHALL hold fetch_pc, a 16-bit next-request address; pm_addr = fetch_pc combinationally.
REQ-015 SHALL drive pm_en = !RST && !flush && (level + inflight < DEPTH), with inflight = 1 when a request was issued last cycle and not cancelled.
REQ-016 SHALL increment fetch_pc by 1 on every cycle with pm_en=1, wrapping 0xFFFF -> 0x0000.
REQ-017 SHALL tag each request with its address and write {pm_data, tag} into the queue tail in the cycle after the request, when inflight=1 and flush=0.
REQ-018 SHALL order entries strictly FIFO; out_instr/out_pc show the head; out_valid = (level != 0).
REQ-019 SHALL remove the head on out_pop=1 with out_valid=1; out_pop with out_valid=0 SHALL be ignored.
REQ-020 SHALL allow push and pop in the same cycle; level stays unchanged.
REQ-021 SHALL never overflow: the inflight reservation in REQ-015 guarantees space for every returning word.
REQ-022 SHALL, on flush=1: set level to 0, clear inflight (the returning word is dropped next cycle), load fetch_pc <= flush_addr, and ignore out_pop and any push that cycle.
REQ-023 SHALL produce, after a flush in cycle N: pm_en=1 with pm_addr=flush_addr in N+1, and out_valid=1 with out_pc=flush_addr in N+3.
REQ-024 SHALL sustain one instruction per cycle in steady state when out_pop is held high.
REQ-025 SHALL treat back-to-back flushes independently; only the last flush_addr takes effect.
REQ-026 SHALL keep read/write pointers modulo DEPTH with wrap-around.

Reset
REQ-027 SHALL, with RST=1, set fetch_pc=0, level=0, inflight=0, pointers=0, and drive pm_en=0, out_valid=0, out_instr=0, out_pc=0.
REQ-028 SHALL give RST priority over flush and out_pop; reset mid-operation drops all queued and in-flight words.
REQ-029 SHALL issue its first request (pm_addr=0) in the first cycle after RST deasserts; out_valid=1 with out_pc=0 two cycles later.

Verification
REQ-030 Reset release with 1-cycle-latency memory, rom[0..7]=0x1000+i, out_pop=0 -> pm_en drops once level+inflight=4; level=4; out_pc=0, out_instr=0x1000; no further requests.
REQ-031 Steady stream, out_pop=1 continuously -> out_pc 0,1,2,3,... on consecutive cycles, no gaps after initial fill.
REQ-032 Flush to 0x0040 while full with a request in flight -> in-flight word dropped; out_valid=0 for two cycles; then out_pc=0x0040, 0x0041, ...
REQ-033 flush=1 and out_pop=1 in same cycle at level=3 -> level=0 next cycle, no pop accounted, stale words never appear.
REQ-034 fetch_pc wrap: flush to 0xFFFE, out_pop=1 -> out_pc 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-035 RST asserted mid-stream at level=2 -> next cycle out_valid=0, pm_en=0; after release refill starts at address 0.
